// File: rtl/ldunit_pkg.sv
// Shared load/store decode constants and FSM state encoding for the Kappa3 memory path.
package ldunit_pkg;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3 == F3_LH || f3 == F3_LHU) && lo[0]) ||
           ((f3 == F3_LW) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/ldunit_if.sv
// Data-memory read port between the load unit (master) and memory (slave).
interface ldunit_if;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, output mem_rd, input mem_ready, input mem_rdata);
  modport slave  (input mem_addr, input mem_rd, output mem_ready, output mem_rdata);
endinterface

// File: rtl/ldunit_ldconv.sv
// Combinational lane select and sign/zero extension of a little-endian read word.
module ldconv
  import ldunit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (lane)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

    data = '0;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data = rdata;
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LHU:  data = {16'h0, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/ldunit.sv
// Kappa3 load unit: captures a load, reads data memory, returns the extended lane.
// Optional misalignment trapping is enabled with LDUNIT_MISALIGN_EN.
module ldunit
  import ldunit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     ir,
  input  logic [31:0]     addr,
  ldunit_if.master        mem,
  output logic [31:0]     out,
  output logic            valid,
  output logic            busy,
  output logic            bus_err,
  output logic            misalign
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, next_state;
  logic [2:0]    funct3_q;
  logic [31:0]   addr_q;
  logic [CW-1:0] counter;
  logic [31:0]   conv_data;
  logic          start_legal, start_mis, timeout;
  logic          unused_ir;

  assign unused_ir = ^{ir[31:15], ir[11:7]};

  ldconv u_ldconv (
    .rdata  (mem.mem_rdata),
    .lane   (addr_q[1:0]),
    .funct3 (funct3_q),
    .data   (conv_data)
  );

  assign mem.mem_addr = {addr_q[31:2], 2'b00};
  assign mem.mem_rd   = (state == ST_REQ);
  assign valid        = (state == ST_DONE);
  assign busy         = (state != ST_IDLE);

  always_comb begin
    next_state  = state;
    start_legal = (ir[6:0] == OP_LOAD) && f3_legal(ir[14:12]);
    start_mis   = 1'b0;
`ifdef LDUNIT_MISALIGN_EN
    start_mis   = start_legal && is_misaligned(ir[14:12], addr[1:0]);
`endif
    timeout     = (counter == CW'(TIMEOUT_CYCLES - 1));
    case (state)
      ST_IDLE: if (start) next_state = (start_legal && !start_mis) ? ST_REQ : ST_DONE;
      ST_REQ:  if (mem.mem_ready || timeout) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Rejected and trapped loads leave out at zero; only a ready REQ cycle writes data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      counter  <= '0;
      out      <= '0;
      bus_err  <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (start) begin
            funct3_q <= ir[14:12];
            addr_q   <= addr;
            counter  <= '0;
            out      <= '0;
            bus_err  <= 1'b0;
          end
        end
        ST_REQ: begin
          if (mem.mem_ready) begin
            out <= conv_data;
          end else if (timeout) begin
            out     <= '0;
            bus_err <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LDUNIT_MISALIGN_EN
  logic mis_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      mis_q <= start_mis;
    end
  end

  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ldunit.sv
// Directed self-checking bench for ldunit (TIMEOUT_CYCLES=4); follows LDUNIT_MISALIGN_EN.
module tb_ldunit;

  localparam logic [31:0] IR_LB  = 32'h0000_0003;
  localparam logic [31:0] IR_LH  = 32'h0000_1003;
  localparam logic [31:0] IR_LW  = 32'h0000_2003;
  localparam logic [31:0] IR_LBU = 32'h0000_4003;
  localparam logic [31:0] IR_LHU = 32'h0000_5003;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  logic [31:0] addr = '0;
  logic [31:0] out;
  logic        valid, busy, bus_err, misalign;
  int          checks = 0;
  int          fails = 0;
  int          lat, rd;

  ldunit_if mem ();

  ldunit #(.TIMEOUT_CYCLES(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .ir       (ir),
    .addr     (addr),
    .mem      (mem.master),
    .out      (out),
    .valid    (valid),
    .busy     (busy),
    .bus_err  (bus_err),
    .misalign (misalign)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One load; memory answers after 'waits' unready REQ cycles. Returns in the valid cycle.
  task automatic applyStimulus(input logic [31:0] ir_v, input logic [31:0] addr_v,
                               input logic [31:0] rdata_v, input int waits,
                               output int lat_o, output int rd_o);
    rd_o = 0;
    mem.mem_ready = 1'b0;
    mem.mem_rdata = rdata_v;
    ir = ir_v;
    addr = addr_v;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat_o = 1;
    while (!valid && lat_o < 64) begin
      if (mem.mem_rd) begin
        rd_o++;
        mem.mem_ready = (rd_o > waits);
      end
      tick();
      lat_o++;
    end
    mem.mem_ready = 1'b0;
  endtask

  task automatic checkLoad(input string tag, input logic [31:0] exp_out, input int exp_lat,
                           input int exp_rd, input logic exp_err, input logic exp_mis);
    checkOutput({tag, " valid"}, {31'b0, valid}, 32'd1);
    checkOutput({tag, " out"}, out, exp_out);
    checkOutput({tag, " latency"}, lat, exp_lat);
    checkOutput({tag, " rd cycles"}, rd, exp_rd);
    checkOutput({tag, " bus_err"}, {31'b0, bus_err}, {31'b0, exp_err});
    checkOutput({tag, " misalign"}, {31'b0, misalign}, {31'b0, exp_mis});
    tick();
    checkOutput({tag, " valid pulse"}, {31'b0, valid}, 32'd0);
    checkOutput({tag, " out held"}, out, exp_out);
  endtask

  initial begin
    mem.mem_ready = 1'b0;
    mem.mem_rdata = '0;
    tick();
    tick();
    checkOutput("reset out", out, 32'h0);
    checkOutput("reset valid", {31'b0, valid}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset mem_rd", {31'b0, mem.mem_rd}, 32'd0);
    checkOutput("reset mem_addr", mem.mem_addr, 32'h0);
    checkOutput("reset bus_err", {31'b0, bus_err}, 32'd0);
    checkOutput("reset misalign", {31'b0, misalign}, 32'd0);
    reset = 1'b0;
    tick();

    // LB lane 3 with manual first-cycle checks
    mem.mem_rdata = 32'h80FF_1234;
    mem.mem_ready = 1'b1;
    ir = IR_LB;
    addr = 32'h103;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("lb mem_rd", {31'b0, mem.mem_rd}, 32'd1);
    checkOutput("lb mem_addr", mem.mem_addr, 32'h100);
    checkOutput("lb busy", {31'b0, busy}, 32'd1);
    checkOutput("lb no early valid", {31'b0, valid}, 32'd0);
    tick();
    mem.mem_ready = 1'b0;
    lat = 2;
    rd = 1;
    checkLoad("lb", 32'hFFFF_FF80, 2, 1, 1'b0, 1'b0);

    applyStimulus(IR_LHU, 32'h202, 32'h9ABC_5678, 3, lat, rd);
    checkLoad("lhu wait3", 32'h0000_9ABC, 5, 4, 1'b0, 1'b0);
    applyStimulus(IR_LH, 32'h202, 32'h9ABC_5678, 0, lat, rd);
    checkLoad("lh upper", 32'hFFFF_9ABC, 2, 1, 1'b0, 1'b0);
    applyStimulus(IR_LBU, 32'h102, 32'h80FF_1234, 1, lat, rd);
    checkLoad("lbu lane2", 32'h0000_00FF, 3, 2, 1'b0, 1'b0);
    applyStimulus(IR_LB, 32'h101, 32'h80FF_1234, 0, lat, rd);
    checkLoad("lb lane1", 32'h0000_0012, 2, 1, 1'b0, 1'b0);

    // LW with a second start during REQ that must not be taken
    mem.mem_rdata = 32'hDEAD_BEEF;
    ir = IR_LW;
    addr = 32'h10;
    start = 1'b1;
    tick();
    ir = IR_LB;
    addr = 32'h203;
    tick();
    start = 1'b0;
    checkOutput("lw addr stable", mem.mem_addr, 32'h10);
    checkOutput("lw still req", {31'b0, mem.mem_rd}, 32'd1);
    mem.mem_ready = 1'b1;
    tick();
    mem.mem_ready = 1'b0;
    lat = 3;
    rd = 2;
    checkLoad("lw ignore start", 32'hDEAD_BEEF, 3, 2, 1'b0, 1'b0);
    checkOutput("lw idle after", {31'b0, busy}, 32'd0);

    applyStimulus(IR_LW, 32'h40, 32'h1111_2222, 1000, lat, rd);
    checkLoad("timeout", 32'h0, 5, 4, 1'b1, 1'b0);
    applyStimulus(IR_LW, 32'h44, 32'h3333_4444, 0, lat, rd);
    checkLoad("after timeout", 32'h3333_4444, 2, 1, 1'b0, 1'b0);

    applyStimulus(32'h0000_0013, 32'h100, 32'h5555_5555, 0, lat, rd);
    checkLoad("non-load", 32'h0, 1, 0, 1'b0, 1'b0);
    applyStimulus(32'h0000_3003, 32'h100, 32'h5555_5555, 0, lat, rd);
    checkLoad("funct3 011", 32'h0, 1, 0, 1'b0, 1'b0);

`ifdef LDUNIT_MISALIGN_EN
    applyStimulus(IR_LH, 32'h101, 32'h1234_F00D, 0, lat, rd);
    checkLoad("lh misaligned", 32'h0, 1, 0, 1'b0, 1'b1);
    applyStimulus(IR_LW, 32'h102, 32'h1234_F00D, 0, lat, rd);
    checkLoad("lw misaligned", 32'h0, 1, 0, 1'b0, 1'b1);
    applyStimulus(IR_LB, 32'h101, 32'h1234_F00D, 0, lat, rd);
    checkLoad("lb clears mis", 32'hFFFF_FFF0, 2, 1, 1'b0, 1'b0);
`else
    applyStimulus(IR_LH, 32'h101, 32'h1234_F00D, 0, lat, rd);
    checkLoad("lh odd addr", 32'hFFFF_F00D, 2, 1, 1'b0, 1'b0);
    applyStimulus(IR_LW, 32'h102, 32'h1234_F00D, 0, lat, rd);
    checkLoad("lw odd addr", 32'h1234_F00D, 2, 1, 1'b0, 1'b0);
`endif

    // Reset while waiting in REQ
    mem.mem_rdata = 32'h80FF_1234;
    mem.mem_ready = 1'b0;
    ir = IR_LB;
    addr = 32'h103;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("rst pre mem_rd", {31'b0, mem.mem_rd}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst mem_rd", {31'b0, mem.mem_rd}, 32'd0);
    checkOutput("rst busy", {31'b0, busy}, 32'd0);
    checkOutput("rst out", out, 32'h0);
    checkOutput("rst mem_addr", mem.mem_addr, 32'h0);
    mem.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst no valid", {31'b0, valid}, 32'd0);
    end
    mem.mem_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
